// File: rtl/instr_issuer.sv
// Instruction issuer: fetches a block of instruction words from synchronous memory
// and pushes them to the controller's decoder queue under credit-based flow control.
module instr_issuer #(
    parameter int unsigned INSTR_SIZE = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned CREDITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_base,
    input  logic [CNT_W-1:0]      cmd_count,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [INSTR_SIZE-1:0] mem_rdata,
    output logic                  instr_valid,
    output logic [INSTR_SIZE-1:0] instr,
    input  logic                  rd_nxt_inst,
    output logic                  busy,
    output logic                  done,
    output logic                  credit_err
);

    localparam int unsigned CR_W = $clog2(CREDITS + 1);
    localparam logic [CR_W-1:0] CR_MAX = CR_W'(CREDITS);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_ptr, addr_next;
    logic [CNT_W-1:0]  remaining, remaining_next;
    logic [CR_W-1:0]   credits, credits_next;
    logic              rd_pending;
    logic              done_next;
    logic              ret_ok;
    logic              err_set;
    logic              err_clr;

    assign mem_addr    = addr_ptr;
    assign instr_valid = rd_pending;
    assign instr       = mem_rdata;

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state == FETCH) || (state == DRAIN);
        mem_rd_en = (state == FETCH) && (remaining != '0) && (credits != '0);
        // A return with a full pool is only legal if a read is consuming a credit this cycle
        ret_ok       = rd_nxt_inst && (mem_rd_en || (credits != CR_MAX));
        err_set      = rd_nxt_inst && !ret_ok;
        credits_next = credits - CR_W'(mem_rd_en) + CR_W'(ret_ok);
    end

    always_comb begin
        state_next     = state;
        addr_next      = addr_ptr;
        remaining_next = remaining;
        done_next      = 1'b0;
        err_clr        = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_next      = cmd_base;
                    remaining_next = cmd_count;
                    err_clr        = 1'b1;
                    if (cmd_count == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (mem_rd_en) begin
                    addr_next      = addr_ptr + ADDR_W'(1);
                    remaining_next = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!rd_pending && (credits_next == CR_MAX)) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_ptr   <= '0;
            remaining  <= '0;
            credits    <= CR_MAX;
            rd_pending <= 1'b0;
            done       <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            state      <= state_next;
            addr_ptr   <= addr_next;
            remaining  <= remaining_next;
            credits    <= credits_next;
            rd_pending <= mem_rd_en;
            done       <= done_next;
            if (err_set) begin
                credit_err <= 1'b1;
            end else if (err_clr) begin
                credit_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: expected addresses/words go into scoreboard queues,
// an independent monitor pops and compares whenever the DUT reads or writes.
module tb_instr_issuer;

    localparam int unsigned INSTR_SIZE = 32;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned CREDITS    = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [ADDR_W-1:0]     cmd_base = '0;
    logic [CNT_W-1:0]      cmd_count = '0;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [INSTR_SIZE-1:0] mem_rdata = '0;
    logic                  instr_valid;
    logic [INSTR_SIZE-1:0] instr;
    logic                  rd_nxt_inst;
    logic                  rd_nxt_man = 1'b0;
    logic                  rd_nxt_auto = 1'b0;
    logic                  busy;
    logic                  done;
    logic                  credit_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ret_delay = 0;
    int ret_q[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_instr[$];

    always #5 clk = ~clk;

    assign rd_nxt_inst = rd_nxt_man | rd_nxt_auto;

    instr_issuer #(
        .INSTR_SIZE(INSTR_SIZE),
        .ADDR_W(ADDR_W),
        .CNT_W(CNT_W),
        .CREDITS(CREDITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_base(cmd_base),
        .cmd_count(cmd_count),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .rd_nxt_inst(rd_nxt_inst),
        .busy(busy),
        .done(done),
        .credit_err(credit_err)
    );

    // Synchronous instruction memory: word content is 0xC0DE in the top half, address below
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= {16'hC0DE, 6'b0, mem_addr};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every read address and every delivered word against the queues
    initial forever begin
        @(negedge clk);
        if (mem_rd_en === 1'b1) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got addr 0x%0h, expected no read", mem_addr);
            end else begin
                check("mem_addr", {22'b0, mem_addr}, {22'b0, exp_addr.pop_front()});
            end
        end
        if (instr_valid === 1'b1) begin
            if (exp_instr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got 0x%0h, expected no instr_valid", instr);
            end else begin
                check("instr", instr, exp_instr.pop_front());
            end
        end
    end

    // Controller model: returns one credit ret_delay cycles after each delivered word
    initial forever begin
        @(negedge clk);
        cyc++;
        rd_nxt_auto = 1'b0;
        if (ret_q.size() > 0 && ret_q[0] == cyc) begin
            void'(ret_q.pop_front());
            rd_nxt_auto = 1'b1;
        end
        if (ret_delay > 0 && instr_valid === 1'b1) ret_q.push_back(cyc + ret_delay);
    end

    task automatic issue(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] count);
        cmd_base  = base;
        cmd_count = count;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int  n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: done never seen within 200 cycles, expected after %0d", name, exp_lat);
        end else begin
            check(name, n, exp_lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_done", done, 0);
        check("rst_credit_err", credit_err, 0);
        check("rst_mem_addr", {22'b0, mem_addr}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic issue, credits returned 2 cycles after each write
        ret_delay = 2;
        for (int i = 0; i < 3; i++) exp_addr.push_back(ADDR_W'(10'h010 + i));
        exp_instr.push_back(32'hC0DE_0010);
        exp_instr.push_back(32'hC0DE_0011);
        exp_instr.push_back(32'hC0DE_0012);
        issue(10'h010, 10'd3);
        wait_done("t1_done_lat", 7);
        check("t1_ready_on_done", cmd_ready, 1);
        check("t1_busy_on_done", busy, 0);
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        ret_delay = 0;
        check("t1_sb_empty", exp_instr.size(), 0);

        // Credit stall: 4 reads then stall; each return lets exactly one more read
        for (int i = 0; i < 6; i++) begin
            exp_addr.push_back(ADDR_W'(10'h100 + i));
            exp_instr.push_back(32'hC0DE_0100 + i);
        end
        issue(10'h100, 10'd6);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            check("t2_rd_en", mem_rd_en, ((c >= 1 && c <= 4) || c == 9 || c == 11) ? 1 : 0);
            check("t2_done", done, (c == 15) ? 1 : 0);
            rd_nxt_man = (c == 8) || (c >= 10 && c <= 14);
        end
        rd_nxt_man = 1'b0;

        // Address wrap with returns coinciding with reads: no stall
        exp_addr.push_back(10'h3FE);
        exp_addr.push_back(10'h3FF);
        exp_addr.push_back(10'h000);
        exp_addr.push_back(10'h001);
        exp_instr.push_back(32'hC0DE_03FE);
        exp_instr.push_back(32'hC0DE_03FF);
        exp_instr.push_back(32'hC0DE_0000);
        exp_instr.push_back(32'hC0DE_0001);
        issue(10'h3FE, 10'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            check("t3_rd_en", mem_rd_en, (c <= 4) ? 1 : 0);
            check("t3_done", done, (c == 7) ? 1 : 0);
            rd_nxt_man = mem_rd_en;
        end
        rd_nxt_man = 1'b0;
        check("t3_credit_err", credit_err, 0);

        // Zero count: immediate done, no read, never busy
        issue(10'h055, 10'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t4_zero_done", done, 1);
        check("t4_zero_busy", busy, 0);
        check("t4_zero_ready", cmd_ready, 1);
        @(negedge clk);
        check("t4_zero_done_pulse", done, 0);

        // Hold-off: second command waits through the first and is accepted on its done cycle
        exp_addr.push_back(10'h200);
        exp_addr.push_back(10'h201);
        exp_addr.push_back(10'h300);
        exp_instr.push_back(32'hC0DE_0200);
        exp_instr.push_back(32'hC0DE_0201);
        exp_instr.push_back(32'hC0DE_0300);
        issue(10'h200, 10'd2);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("t4_cmd_ready", cmd_ready, (c == 5 || c >= 9) ? 1 : 0);
            check("t4_done", done, (c == 5 || c == 9) ? 1 : 0);
            check("t4_rd_en", mem_rd_en, (c == 1 || c == 2 || c == 6) ? 1 : 0);
            if (c == 1) issue(10'h300, 10'd1);
            if (c == 6) cmd_valid = 1'b0;
            rd_nxt_man = instr_valid;
        end
        rd_nxt_man = 1'b0;

        // Credit error in IDLE; pool must stay at 4 and the next command clears the flag
        for (int i = 0; i < 5; i++) begin
            exp_addr.push_back(ADDR_W'(10'h040 + i));
            exp_instr.push_back(32'hC0DE_0040 + i);
        end
        rd_nxt_man = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            check("t5_credit_err", credit_err, (c == 1) ? 1 : 0);
            check("t5_rd_en", mem_rd_en, ((c >= 2 && c <= 5) || c == 9) ? 1 : 0);
            check("t5_done", done, (c == 13) ? 1 : 0);
            rd_nxt_man = (c >= 8 && c <= 12);
            if (c == 1) issue(10'h040, 10'd5);
            if (c == 2) cmd_valid = 1'b0;
        end
        rd_nxt_man = 1'b0;

        // Reset right after a read issues: the in-flight word must never appear
        exp_addr.push_back(10'h080);
        issue(10'h080, 10'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_instr_valid", instr_valid, 0);
        check("t6_rd_en", mem_rd_en, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_credit_err", credit_err, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        check("t6_mem_addr", {22'b0, mem_addr}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6_post_ready", cmd_ready, 1);
        check("t6_post_valid", instr_valid, 0);
        ret_delay = 2;
        exp_addr.push_back(10'h0A0);
        exp_addr.push_back(10'h0A1);
        exp_instr.push_back(32'hC0DE_00A0);
        exp_instr.push_back(32'hC0DE_00A1);
        issue(10'h0A0, 10'd2);
        wait_done("t6_done_lat", 6);
        check("t6_busy_after", busy, 0);
        ret_delay = 0;

        repeat (2) @(negedge clk);
        check("sb_addr_empty", exp_addr.size(), 0);
        check("sb_instr_empty", exp_instr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
